// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: read ports, write port and scoreboard issue port.
// Clock and reset stay as plain ports on the module.
interface register_file_sb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] Read_Register1;
   logic [ADDR_WIDTH-1:0] Read_Register2;
   logic [DATA_WIDTH-1:0] Read_Data1;
   logic [DATA_WIDTH-1:0] Read_Data2;
   logic                  Read_Busy1;
   logic                  Read_Busy2;
   logic                  Write_Enable;
   logic [ADDR_WIDTH-1:0] Write_Register;
   logic [DATA_WIDTH-1:0] Write_Data;
   logic                  Issue_Valid;
   logic [ADDR_WIDTH-1:0] Issue_Register;
   logic                  Issue_Stall;

   modport master (
      output Read_Register1, Read_Register2,
      output Write_Enable, Write_Register, Write_Data,
      output Issue_Valid, Issue_Register,
      input  Read_Data1, Read_Data2, Read_Busy1, Read_Busy2, Issue_Stall
   );

   modport slave (
      input  Read_Register1, Read_Register2,
      input  Write_Enable, Write_Register, Write_Data,
      input  Issue_Valid, Issue_Register,
      output Read_Data1, Read_Data2, Read_Busy1, Read_Busy2, Issue_Stall
   );
endinterface

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module register_file_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                Clock,
   input  logic                Reset_n,
   register_file_sb_if.slave   bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_busy;
   logic [DATA_WIDTH-1:0] r_rd_data1;
   logic [DATA_WIDTH-1:0] r_rd_data2;
   logic                  r_rd_busy1;
   logic                  r_rd_busy2;

   logic [DEPTH-1:0]      w_busy_next;
   logic                  w_wr_zero;
   logic                  w_wr_en;
   logic                  w_iss_zero;
   logic                  w_wr_hits_iss;
   logic                  w_stall;
   logic                  w_iss_acc;
   logic [DATA_WIDTH-1:0] w_rd_data1;
   logic [DATA_WIDTH-1:0] w_rd_data2;
   logic                  w_rd_busy1;
   logic                  w_rd_busy2;

   assign w_wr_zero     = (ZERO_REG != 0) && (bus.Write_Register == '0);
   assign w_iss_zero    = (ZERO_REG != 0) && (bus.Issue_Register == '0);
   assign w_wr_en       = bus.Write_Enable && !w_wr_zero;
   assign w_wr_hits_iss = bus.Write_Enable && (bus.Write_Register == bus.Issue_Register);

   // Issue handshake: Issue_Valid requests a destination; Issue_Stall is the
   // combinational back-pressure; the issue is taken at the edge iff Valid && !Stall.
   // A write retiring the same register in the same cycle releases the stall.
   assign w_stall   = Reset_n && bus.Issue_Valid && r_busy[bus.Issue_Register] && !w_wr_hits_iss;
   assign w_iss_acc = bus.Issue_Valid && !w_stall && !w_iss_zero;
   assign bus.Issue_Stall = w_stall;

   // Set after clear so a new producer wins over the retiring write.
   always_comb begin
      w_busy_next = r_busy;
      if (w_wr_en)   w_busy_next[bus.Write_Register] = 1'b0;
      if (w_iss_acc) w_busy_next[bus.Issue_Register] = 1'b1;
   end

   always_comb begin
      w_rd_data1 = r_regs[bus.Read_Register1];
      w_rd_data2 = r_regs[bus.Read_Register2];
      w_rd_busy1 = r_busy[bus.Read_Register1];
      w_rd_busy2 = r_busy[bus.Read_Register2];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (bus.Write_Register == bus.Read_Register1)) begin
         w_rd_data1 = bus.Write_Data;
         w_rd_busy1 = w_busy_next[bus.Read_Register1];
      end
      if (w_wr_en && (bus.Write_Register == bus.Read_Register2)) begin
         w_rd_data2 = bus.Write_Data;
         w_rd_busy2 = w_busy_next[bus.Read_Register2];
      end
`else
      // Read-before-write: a same-cycle write becomes visible on the next read.
`endif
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_busy     <= '0;
         r_rd_data1 <= '0;
         r_rd_data2 <= '0;
         r_rd_busy1 <= 1'b0;
         r_rd_busy2 <= 1'b0;
      end else begin
         if (w_wr_en) r_regs[bus.Write_Register] <= bus.Write_Data;
         r_busy     <= w_busy_next;
         r_rd_data1 <= w_rd_data1;
         r_rd_data2 <= w_rd_data2;
         r_rd_busy1 <= w_rd_busy1;
         r_rd_busy2 <= w_rd_busy2;
      end
   end

   assign bus.Read_Data1 = r_rd_data1;
   assign bus.Read_Data2 = r_rd_data2;
   assign bus.Read_Busy1 = r_rd_busy1;
   assign bus.Read_Busy2 = r_rd_busy2;
endmodule
